// File: rtl/debug_rom_pipe.sv
// Pipelined, parametrised debug ROM with req/gnt request handshake, credit-based
// flow control and a back-pressured rvalid/rready response FIFO.
module debug_rom_pipe #(
  parameter int unsigned                DataWidth = 64,
  parameter int unsigned                Depth     = 19,
  parameter int unsigned                AddrWidth = 64,
  parameter int unsigned                Latency   = 1,
  parameter logic [Depth*DataWidth-1:0] Init      = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 rerror_o
);

  localparam int unsigned OffW      = $clog2(DataWidth / 8);
  localparam int unsigned FifoDepth = Latency + 1;
  localparam int unsigned CntW      = $clog2(Latency + 2);
  localparam int unsigned PtrW      = $clog2(FifoDepth);
  localparam int unsigned FCntW     = $clog2(FifoDepth + 1);

  // Address decode
  logic [7:0]           idx;
  logic                 hi_err;
  logic                 dec_err;
  logic [DataWidth-1:0] rom_word;
  logic [DataWidth-1:0] dec_data;

  assign idx = addr_i[OffW +: 8];

  if (AddrWidth > OffW + 8) begin : g_hi
    assign hi_err = |addr_i[AddrWidth-1:OffW+8];
  end else begin : g_no_hi
    assign hi_err = 1'b0;
  end

  assign dec_err = ({1'b0, idx} >= 9'(Depth)) || (|addr_i[OffW-1:0]) || hi_err;

  always_comb begin
    rom_word = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (idx == 8'(i)) rom_word = Init[i*DataWidth +: DataWidth];
    end
  end

  assign dec_data = dec_err ? '0 : rom_word;

  // Each accepted request holds a credit until its response is popped, so the
  // FIFO can never receive more than Latency+1 entries.
  logic [CntW-1:0] cnt;
  logic            accept;
  logic            pop;
  logic            push;

  assign gnt_o  = rst_ni && (cnt < CntW'(Latency + 1));
  assign accept = req_i && gnt_o;
  assign pop    = rvalid_o && rready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (accept && !pop) begin
      cnt <= cnt + CntW'(1);
    end else if (!accept && pop) begin
      cnt <= cnt - CntW'(1);
    end
  end

  // Read pipeline: advances unconditionally every cycle
  logic [Latency-1:0]   pv;
  logic [Latency-1:0]   pe;
  logic [DataWidth-1:0] pd [Latency];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pv <= '0;
      pe <= '0;
      for (int unsigned i = 0; i < Latency; i++) pd[i] <= '0;
    end else begin
      pv[0] <= accept;
      pe[0] <= dec_err;
      pd[0] <= dec_data;
      for (int unsigned i = 1; i < Latency; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign push = pv[Latency-1];

  // Response FIFO
  logic [DataWidth-1:0] fd [FifoDepth];
  logic [FifoDepth-1:0] fe;
  logic [PtrW-1:0]      wp;
  logic [PtrW-1:0]      rp;
  logic [FCntW-1:0]     fcnt;
  logic                 full;

  assign full = (fcnt == FCntW'(FifoDepth));

  always_ff @(posedge clk_i) begin
    if (push) begin
      fd[wp] <= pd[Latency-1];
      fe[wp] <= pe[Latency-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else begin
      if (push) wp <= (wp == PtrW'(FifoDepth - 1)) ? '0 : wp + PtrW'(1);
      if (pop)  rp <= (rp == PtrW'(FifoDepth - 1)) ? '0 : rp + PtrW'(1);
      if (push && !pop)      fcnt <= fcnt + FCntW'(1);
      else if (!push && pop) fcnt <= fcnt - FCntW'(1);
    end
  end

  assign rvalid_o = (fcnt != '0);
  assign rdata_o  = rvalid_o ? fd[rp] : '0;
  assign rerror_o = rvalid_o && fe[rp];

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));

endmodule

// File: tb/tb_debug_rom_pipe.sv
// Directed self-checking bench for debug_rom_pipe: three instances cover
// 64-bit/Latency 1, 64-bit/Latency 2 and 32-bit/Depth 4 configurations.
module tb_debug_rom_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [63:0] w64(input int unsigned i);
    if (i == 3) return 64'h0123_4567_89AB_CDEF;
    return {32'hD00D_0000 + i, 32'hCAFE_0000 + i};
  endfunction

  function automatic logic [31:0] w32(input int unsigned i);
    return 32'h3000_0000 + i * 17;
  endfunction

  function automatic logic [19*64-1:0] mk_init64();
    logic [19*64-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < 19; i++) v[i*64 +: 64] = w64(i);
    return v;
  endfunction

  function automatic logic [4*32-1:0] mk_init32();
    logic [4*32-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < 4; i++) v[i*32 +: 32] = w32(i);
    return v;
  endfunction

  localparam logic [19*64-1:0] INIT64 = mk_init64();
  localparam logic [4*32-1:0]  INIT32 = mk_init32();

  logic        req1, gnt1, rvalid1, rready1, rerror1;
  logic [63:0] addr1, rdata1;
  logic        req2, gnt2, rvalid2, rready2, rerror2;
  logic [63:0] addr2, rdata2;
  logic        req3, gnt3, rvalid3, rready3, rerror3;
  logic [63:0] addr3;
  logic [31:0] rdata3;

  debug_rom_pipe #(.DataWidth(64), .Depth(19), .AddrWidth(64), .Latency(1), .Init(INIT64)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .addr_i(addr1), .gnt_o(gnt1),
    .rvalid_o(rvalid1), .rready_i(rready1), .rdata_o(rdata1), .rerror_o(rerror1)
  );

  debug_rom_pipe #(.DataWidth(64), .Depth(19), .AddrWidth(64), .Latency(2), .Init(INIT64)) u_l2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .addr_i(addr2), .gnt_o(gnt2),
    .rvalid_o(rvalid2), .rready_i(rready2), .rdata_o(rdata2), .rerror_o(rerror2)
  );

  debug_rom_pipe #(.DataWidth(32), .Depth(4), .AddrWidth(64), .Latency(1), .Init(INIT32)) u_w32 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req3), .addr_i(addr3), .gnt_o(gnt3),
    .rvalid_o(rvalid3), .rready_i(rready3), .rdata_o(rdata3), .rerror_o(rerror3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (gnt1 !== 1'b0) begin failures++; $display("FAIL reset_gnt_low: got %b expected 0", gnt1); end
    checks++; if (rvalid1 !== 1'b0 || rvalid2 !== 1'b0 || rvalid3 !== 1'b0) begin
      failures++; $display("FAIL reset_rvalid: got %b%b%b expected 000", rvalid1, rvalid2, rvalid3); end
    checks++; if (rdata1 !== 64'h0 || rerror1 !== 1'b0) begin
      failures++; $display("FAIL reset_rdata: got %h/%b expected 0/0", rdata1, rerror1); end
    rst_n = 1'b1;
    #1;
    checks++; if (gnt1 !== 1'b1 || gnt2 !== 1'b1 || gnt3 !== 1'b1) begin
      failures++; $display("FAIL reset_gnt_release: got %b%b%b expected 111", gnt1, gnt2, gnt3); end
  endtask

  task automatic test_basic();
    rready1 = 1'b1; req1 = 1'b1; addr1 = 64'h18;
    checks++; if (gnt1 !== 1'b1) begin failures++; $display("FAIL basic_gnt: got %b expected 1", gnt1); end
    tick();
    req1 = 1'b0;
    checks++; if (rvalid1 !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b expected 0", rvalid1); end
    tick();
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== 64'h0123_4567_89AB_CDEF || rerror1 !== 1'b0) begin
      failures++; $display("FAIL basic_resp: got %b %h %b expected 1 0123456789abcdef 0", rvalid1, rdata1, rerror1); end
    tick();
    checks++; if (rvalid1 !== 1'b0) begin failures++; $display("FAIL basic_pop: got %b expected 0", rvalid1); end
  endtask

  task automatic test_back_pressure();
    rready1 = 1'b0; req1 = 1'b1; addr1 = 64'h0;
    checks++; if (gnt1 !== 1'b1) begin failures++; $display("FAIL bp_gnt0: got %b expected 1", gnt1); end
    tick();
    addr1 = 64'h8;
    checks++; if (gnt1 !== 1'b1) begin failures++; $display("FAIL bp_gnt1: got %b expected 1", gnt1); end
    tick();
    addr1 = 64'h10;
    checks++; if (gnt1 !== 1'b0) begin failures++; $display("FAIL bp_gnt_stall: got %b expected 0", gnt1); end
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== w64(0)) begin
      failures++; $display("FAIL bp_head: got %b %h expected 1 %h", rvalid1, rdata1, w64(0)); end
    repeat (2) begin
      tick();
      checks++; if (gnt1 !== 1'b0 || rvalid1 !== 1'b1 || rdata1 !== w64(0)) begin
        failures++; $display("FAIL bp_hold: got gnt=%b v=%b %h expected 0 1 %h", gnt1, rvalid1, rdata1, w64(0)); end
    end
    rready1 = 1'b1;
    tick();
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== w64(1) || gnt1 !== 1'b1) begin
      failures++; $display("FAIL bp_pop0: got v=%b %h gnt=%b expected 1 %h 1", rvalid1, rdata1, gnt1, w64(1)); end
    tick();
    req1 = 1'b0;
    checks++; if (rvalid1 !== 1'b0) begin failures++; $display("FAIL bp_pop1: got %b expected 0", rvalid1); end
    tick();
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== w64(2)) begin
      failures++; $display("FAIL bp_third: got %b %h expected 1 %h", rvalid1, rdata1, w64(2)); end
    tick();
    checks++; if (rvalid1 !== 1'b0) begin failures++; $display("FAIL bp_drain: got %b expected 0", rvalid1); end
  endtask

  task automatic test_errors();
    logic [63:0] a [4];
    logic        e [4];
    logic [63:0] d [4];
    a[0] = 64'h98;  e[0] = 1'b1; d[0] = 64'h0;
    a[1] = 64'h04;  e[1] = 1'b1; d[1] = 64'h0;
    a[2] = 64'h90;  e[2] = 1'b0; d[2] = w64(18);
    a[3] = 64'h818; e[3] = 1'b1; d[3] = 64'h0;
    rready1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req1 = 1'b1; addr1 = a[k];
      checks++; if (gnt1 !== 1'b1) begin failures++; $display("FAIL err_gnt[%0d]: got %b expected 1", k, gnt1); end
      tick();
      req1 = 1'b0;
      tick();
      checks++; if (rvalid1 !== 1'b1 || rerror1 !== e[k] || rdata1 !== d[k]) begin
        failures++; $display("FAIL err_resp[%0d]: got v=%b e=%b %h expected 1 %b %h", k, rvalid1, rerror1, rdata1, e[k], d[k]); end
      tick();
    end
  endtask

  task automatic test_stream();
    int  sent, got, acc_cyc;
    bit  acc;
    sent = 0; got = 0; acc_cyc = 0;
    rready2 = 1'b1; req2 = 1'b1; addr2 = 64'h0;
    for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
      acc = req2 && gnt2;
      if (acc && sent == 0) acc_cyc = cyc;
      tick();
      if (acc) begin
        sent++;
        if (sent == 16) req2 = 1'b0;
        else addr2 = 64'(sent * 8);
      end
      if (rvalid2) begin
        if (got == 0) begin
          checks++; if (cyc - acc_cyc != 2) begin
            failures++; $display("FAIL stream_latency: got %0d expected 2", cyc - acc_cyc); end
        end
        checks++; if (rdata2 !== w64(got) || rerror2 !== 1'b0) begin
          failures++; $display("FAIL stream_word[%0d]: got %h e=%b expected %h 0", got, rdata2, rerror2, w64(got)); end
        got++;
      end
    end
    checks++; if (got != 16) begin failures++; $display("FAIL stream_count: got %0d expected 16", got); end
    req2 = 1'b0;
    repeat (3) tick();
    checks++; if (rvalid2 !== 1'b0) begin failures++; $display("FAIL stream_extra: got %b expected 0", rvalid2); end
  endtask

  task automatic test_dw32();
    logic [63:0] a [4];
    logic        e [4];
    logic [31:0] d [4];
    a[0] = 64'h0C; e[0] = 1'b0; d[0] = 32'h3000_0033;
    a[1] = 64'h10; e[1] = 1'b1; d[1] = 32'h0;
    a[2] = 64'h02; e[2] = 1'b1; d[2] = 32'h0;
    a[3] = 64'h00; e[3] = 1'b0; d[3] = 32'h3000_0000;
    rready3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req3 = 1'b1; addr3 = a[k];
      checks++; if (gnt3 !== 1'b1) begin failures++; $display("FAIL w32_gnt[%0d]: got %b expected 1", k, gnt3); end
      tick();
      req3 = 1'b0;
      tick();
      checks++; if (rvalid3 !== 1'b1 || rerror3 !== e[k] || rdata3 !== d[k]) begin
        failures++; $display("FAIL w32_resp[%0d]: got v=%b e=%b %h expected 1 %b %h", k, rvalid3, rerror3, rdata3, e[k], d[k]); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    rready1 = 1'b0; req1 = 1'b1; addr1 = 64'h0;
    tick();
    addr1 = 64'h8;
    tick();
    req1 = 1'b0;
    tick();
    checks++; if (rvalid1 !== 1'b1) begin failures++; $display("FAIL mid_pending: got %b expected 1", rvalid1); end
    rst_n = 1'b0;
    tick();
    checks++; if (rvalid1 !== 1'b0 || rdata1 !== 64'h0 || gnt1 !== 1'b0) begin
      failures++; $display("FAIL mid_in_reset: got v=%b %h gnt=%b expected 0 0 0", rvalid1, rdata1, gnt1); end
    rst_n = 1'b1;
    #1;
    checks++; if (gnt1 !== 1'b1) begin failures++; $display("FAIL mid_gnt: got %b expected 1", gnt1); end
    rready1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (rvalid1 !== 1'b0) begin failures++; $display("FAIL mid_stale[%0d]: got %b expected 0", k, rvalid1); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req1 = 1'b0; addr1 = '0; rready1 = 1'b0;
    req2 = 1'b0; addr2 = '0; rready2 = 1'b0;
    req3 = 1'b0; addr3 = '0; rready3 = 1'b0;
    test_reset();
    test_basic();
    test_back_pressure();
    test_errors();
    test_stream();
    test_dw32();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/debug_rom_pipe.md
Name: debug_rom_pipe

Overview:
Parametrised, pipelined read-only memory for the debug module's program buffer and debug ROM image. It generalises the fixed 64-bit, single-cycle debug ROM. Data width, depth, image contents and read latency are parameters. It adds a req/gnt request handshake, a back-pressured rvalid/rready response channel with an internal response FIFO, and an error flag for out-of-range or misaligned accesses. It sits between the debug-module bus adapter and the ROM image supplied by the top level.

Parameters:
- DataWidth, 64, word width in bits; power of two, 32 or 64.
- Depth, 19, number of words; 1..256.
- AddrWidth, 64, width of the byte address input.
- Latency, 1, cycles from request accept to response at the FIFO input; 1 or 2.
- Init, all zeros, Depth*DataWidth-bit image; word i is Init[i*DataWidth +: DataWidth].

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- req_i  in  1  read request
- addr_i  in  AddrWidth  byte address
- gnt_o  out  1  request accepted this cycle when req_i && gnt_o
- rvalid_o  out  1  response valid
- rready_i  in  1  response consumed when rvalid_o && rready_i
- rdata_o  out  DataWidth  read data
- rerror_o  out  1  access error for the presented response

Behaviour:
- Reset (rst_ni low at a clk_i edge) clears:
  - pipeline valid bits
  - FIFO pointers and count
  - outstanding counter
- After reset: rvalid_o=0, rdata_o=0, rerror_o=0.
- gnt_o is forced 0 while rst_ni is low.
- Address decode:
  - OffW = log2(DataWidth/8); word index idx = addr_i[OffW +: 8].
  - Error if idx >= Depth, or addr_i[OffW-1:0] != 0, or any address bit above OffW+8 is set.
  - On error, the response carries rdata=0 and rerror=1.
  - Otherwise it carries Init word idx and rerror=0.
- Outstanding counter:
  - cnt counts accepted requests not yet popped; range 0..Latency+1.
  - +1 on accept, -1 on pop; both in the same cycle leaves it unchanged.
- gnt_o = (cnt < Latency+1). It is registered-state derived only: no combinational path from rready_i or req_i.
- Pipeline: the accepted request's data/error enters stage 1. Stages advance every cycle unconditionally.
  - After Latency cycles the result is written into the response FIFO (depth Latency+1).
  - The credit scheme guarantees the FIFO never overflows. An assertion flags push while full.
- Response:
  - rvalid_o = FIFO non-empty. rdata_o/rerror_o show the FIFO head and read 0 when empty.
  - Head is stable while rvalid_o && !rready_i.
  - Pop on rvalid_o && rready_i.
- Latency: a request accepted at edge N gives rvalid_o=1 from edge N+Latency, if the FIFO was empty.
- Throughput: with rready_i held high, one response per cycle, no bubbles.
- Ordering: responses are strictly in request order.
- Reset mid-operation: all in-flight and buffered responses are discarded. No response appears after reset for pre-reset requests.
- Simultaneous accept and pop with cnt=Latency+1 cannot occur, because gnt_o=0.

Test Plan:
- Reset, then Latency=1, DataWidth=64, Init word 3 = 64'h0123_4567_89AB_CDEF, req addr 0x18 at cycle N -> gnt_o=1; at N+1 rvalid_o=1, rdata_o=64'h0123_4567_89AB_CDEF, rerror_o=0.
- Back-pressure, Latency=1: rready_i=0, requests to addrs 0x0, 0x8, 0x10 back-to-back -> two grants, then gnt_o=0. rdata_o holds word 0 stable. Raise rready_i -> words 0 and 1 pop in order, then the third request is granted.
- Streaming, Latency=2: rready_i=1, 16 consecutive requests to addrs 0x0..0x78 -> first rvalid_o at accept+2, then 16 consecutive valid cycles with words 0..15 in order.
- Error cases, Depth=19: addr 0x98 (idx 19) -> rerror_o=1, rdata_o=0. Addr 0x04 (misaligned) -> rerror_o=1. Addr 0x90 -> valid word 18, rerror_o=0.
- Reset mid-operation: two requests outstanding with rready_i=0, assert rst_ni=0 for 1 cycle -> rvalid_o=0 and gnt_o=1 after release. No stale responses ever appear.
- DataWidth=32, Depth=4: addr 0x0C -> word 3. Addr 0x10 -> rerror_o=1. Addr 0x02 -> rerror_o=1.
